// File: rtl/t05_serial_histogram_top.sv
// Character-frequency front end: deserialises a 7-bit ASCII stream on miso,
// keeps a 128-bin saturating histogram with a running most-frequent tracker,
// and reports {max_char, max_cnt} as a 16-bit serial frame on mosi.
//
// state    | meaning
// RX_HUNT  | receiver unlocked, waiting for a rising edge on miso in READ
// RX_LOCK  | receiver locked, bit-cycle counter and bit index free-running
// TX_IDLE  | mosi held low, waiting for a rising entry into WRITE
// TX_SEND  | shifting the latched 16-bit result frame out on mosi
module t05_serial_histogram_top #(
    parameter int BIT_CYCLES = 3,
    parameter int SAMPLE_IDX = 1
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] en_state,
    input  logic       miso,
    output logic       mosi
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_SAMPLE = CW'(SAMPLE_IDX);

    typedef enum logic {RX_HUNT, RX_LOCK} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    logic mode_read;
    logic mode_write;
    assign mode_read  = (en_state == 4'd5);
    assign mode_write = (en_state == 4'd6);

    // receiver registers
    rx_state_t     rx_state_q;
    logic          miso_prev_q;
    logic [CW-1:0] rx_cyc_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          commit_q;
    logic [7:0]    commit_byte_q;

    // histogram and running maximum
    logic [7:0]    hist_q [128];
    logic [6:0]    max_char_q;
    logic [7:0]    max_cnt_q;

    // transmitter registers
    tx_state_t     tx_state_q;
    logic          write_prev_q;
    logic [CW-1:0] tx_cyc_q;
    logic [3:0]    tx_bit_q;
    logic [15:0]   tx_sh_q;
    logic          mosi_q;

    // receiver next-state
    logic          rx_locked;
    logic          rx_active_d;
    logic [CW-1:0] cur_cyc;
    logic [2:0]    cur_bit;
    logic [7:0]    cur_sh;
    logic          rx_sample;
    logic [7:0]    rx_sh_d;
    logic          rx_done_d;
    logic [CW-1:0] rx_cyc_d;
    logic [2:0]    rx_bit_d;

    // An unlocked receiver that sees a rising edge treats this very cycle as
    // cycle 0 of bit 6 with bit 7 already shifted in as 0.
    always_comb begin
        rx_locked   = (rx_state_q == RX_LOCK);
        rx_active_d = mode_read && (rx_locked || (miso && !miso_prev_q));
        cur_cyc     = rx_locked ? rx_cyc_q : '0;
        cur_bit     = rx_locked ? rx_bit_q : 3'd6;
        cur_sh      = rx_locked ? rx_sh_q  : 8'd0;
        rx_sample   = (cur_cyc == CYC_SAMPLE);
        rx_sh_d     = rx_sample ? {cur_sh[6:0], miso} : cur_sh;
        rx_done_d   = rx_active_d && rx_sample && (cur_bit == 3'd0);
        if (cur_cyc == CYC_LAST) begin
            rx_cyc_d = '0;
            rx_bit_d = cur_bit - 3'd1;
        end else begin
            rx_cyc_d = cur_cyc + CW'(1);
            rx_bit_d = cur_bit;
        end
    end

    // Receiver FSM: lock on edge, sample each bit, flag completed bytes for commit
    always_ff @(posedge hwclk) begin
        if (reset) begin
            rx_state_q    <= RX_HUNT;
            miso_prev_q   <= 1'b0;
            rx_cyc_q      <= '0;
            rx_bit_q      <= 3'd0;
            rx_sh_q       <= 8'd0;
            commit_q      <= 1'b0;
            commit_byte_q <= 8'd0;
        end else begin
            miso_prev_q <= miso;
            commit_q    <= rx_done_d;
            if (rx_done_d) begin
                commit_byte_q <= rx_sh_d;
            end
            if (rx_active_d) begin
                rx_state_q <= RX_LOCK;
                rx_cyc_q   <= rx_cyc_d;
                rx_bit_q   <= rx_bit_d;
                rx_sh_q    <= rx_sh_d;
            end else begin
                rx_state_q <= RX_HUNT;
            end
        end
    end

    logic [6:0] code;
    logic [7:0] bin_new_d;
    logic       hist_we;
    logic       max_upd;

    // Saturating increment; ties on count go to the lower character code
    always_comb begin
        code      = commit_byte_q[6:0];
        bin_new_d = (hist_q[code] == 8'hFF) ? 8'hFF : hist_q[code] + 8'd1;
        hist_we   = commit_q && !commit_byte_q[7];
        max_upd   = hist_we && ((bin_new_d > max_cnt_q) ||
                                ((bin_new_d == max_cnt_q) && (code < max_char_q)));
    end

    // Histogram bins and most-frequent tracker; only reset clears them
    always_ff @(posedge hwclk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                hist_q[i] <= 8'd0;
            end
            max_char_q <= 7'd0;
            max_cnt_q  <= 8'd0;
        end else if (hist_we) begin
            hist_q[code] <= bin_new_d;
            if (max_upd) begin
                max_char_q <= code;
                max_cnt_q  <= bin_new_d;
            end
        end
    end

    logic [15:0] frame_d;
    assign frame_d = {1'b0, max_char_q, max_cnt_q};

    // Transmitter FSM: one frame per rising entry into WRITE, abort on exit
    always_ff @(posedge hwclk) begin
        if (reset) begin
            tx_state_q   <= TX_IDLE;
            write_prev_q <= 1'b0;
            tx_cyc_q     <= '0;
            tx_bit_q     <= 4'd0;
            tx_sh_q      <= 16'd0;
            mosi_q       <= 1'b0;
        end else begin
            write_prev_q <= mode_write;
            case (tx_state_q)
                TX_IDLE: begin
                    if (mode_write && !write_prev_q) begin
                        tx_state_q <= TX_SEND;
                        tx_sh_q    <= frame_d;
                        tx_cyc_q   <= '0;
                        tx_bit_q   <= 4'd0;
                        mosi_q     <= frame_d[15];
                    end else begin
                        mosi_q <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (!mode_write) begin
                        tx_state_q <= TX_IDLE;
                        mosi_q     <= 1'b0;
                    end else if (tx_cyc_q == CYC_LAST) begin
                        tx_cyc_q <= '0;
                        if (tx_bit_q == 4'd15) begin
                            tx_state_q <= TX_IDLE;
                            mosi_q     <= 1'b0;
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                            tx_sh_q  <= {tx_sh_q[14:0], 1'b0};
                            mosi_q   <= tx_sh_q[14];
                        end
                    end else begin
                        tx_cyc_q <= tx_cyc_q + CW'(1);
                        mosi_q   <= tx_sh_q[15];
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    mosi_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mosi = mosi_q;

endmodule

// File: tb/tb_t05_serial_histogram_top.sv
// Bench for t05_serial_histogram_top: table of short streams with known
// results, hand-written corner sequences, and randomized sessions checked
// against a bin-array reference model.
module tb_t05_serial_histogram_top;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] en_state = 4'd0;
    logic       miso = 1'b0;
    logic       mosi;

    t05_serial_histogram_top dut (
        .hwclk    (hwclk),
        .reset    (reset),
        .en_state (en_state),
        .miso     (miso),
        .mosi     (mosi)
    );

    always #5 hwclk = ~hwclk;

    int checks = 0;
    int failures = 0;
    int mbins [128];

    typedef struct {
        int               n;
        logic [0:5][7:0]  b;
        logic [7:0]       exp_char;
        logic [7:0]       exp_cnt;
        string            name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_add(input logic [7:0] b);
        if (!b[7]) begin
            if (mbins[b[6:0]] < 255) mbins[b[6:0]] = mbins[b[6:0]] + 1;
        end
    endfunction

    // Most frequent character: highest count, lowest code on ties
    function automatic void model_max(output logic [7:0] c, output logic [7:0] n);
        int best = 0;
        int bc = 0;
        for (int i = 0; i < 128; i++) begin
            if (mbins[i] > best) begin
                best = mbins[i];
                bc = i;
            end
        end
        c = 8'(bc);
        n = 8'(best);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        en_state = 4'd0;
        miso = 1'b0;
        repeat (2) @(negedge hwclk);
        reset = 1'b0;
        for (int i = 0; i < 128; i++) mbins[i] = 0;
    endtask

    // First byte starts at its bit 6 (bit 7 implied 0); later bytes are 8 bits, back to back
    task automatic send_stream(input logic [7:0] q[$]);
        en_state = 4'd5;
        miso = 1'b0;
        repeat (2) @(negedge hwclk);
        for (int i = 0; i < q.size(); i++) begin
            for (int b = (i == 0) ? 6 : 7; b >= 0; b--) begin
                miso = q[i][b];
                repeat (3) @(negedge hwclk);
            end
            model_add((i == 0) ? {1'b0, q[i][6:0]} : q[i]);
        end
        miso = 1'b0;
        en_state = 4'd0;
        @(negedge hwclk);
    endtask

    task automatic check_frame(input logic [7:0] ec, input logic [7:0] ecnt, input string name);
        logic [15:0] exp_w;
        logic [15:0] got;
        int bad;
        exp_w = {ec, ecnt};
        got = 16'd0;
        bad = 0;
        en_state = 4'd6;
        for (int k = 0; k < 48; k++) begin
            @(negedge hwclk);
            if (k % 3 == 1) got[15 - k/3] = mosi;
            if (mosi !== exp_w[15 - k/3]) bad++;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge hwclk);
            if (mosi !== 1'b0) bad++;
        end
        en_state = 4'd0;
        @(negedge hwclk);
        chk({name, "_frame"}, 32'(got), 32'(exp_w));
        chk({name, "_timing"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t tbl [7];
        logic [7:0] q[$];
        logic [7:0] mc, mn;
        logic [3:0] idle_vals [5] = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15};

        tbl[0] = '{1, {8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h41, 8'h01, "t_A"};
        tbl[1] = '{3, {8'h41, 8'h42, 8'h42, 8'h00, 8'h00, 8'h00}, 8'h42, 8'h02, "t_ABB"};
        tbl[2] = '{2, {8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h41, 8'h01, "t_AB_tie"};
        tbl[3] = '{2, {8'h42, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h41, 8'h01, "t_BA_tie"};
        tbl[4] = '{2, {8'h41, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h41, 8'h01, "t_bit7_drop"};
        tbl[5] = '{5, {8'h5A, 8'h61, 8'h61, 8'h5A, 8'h5A, 8'h00}, 8'h5A, 8'h03, "t_Zaa"};
        tbl[6] = '{3, {8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h02, "t_nul"};

        @(negedge hwclk);
        do_reset();
        chk("reset_mosi", 32'(mosi), 32'd0);

        // T1: READ with miso held low never locks
        en_state = 4'd5;
        repeat (5000) @(negedge hwclk);
        en_state = 4'd0;
        @(negedge hwclk);
        check_frame(8'h00, 8'h00, "T1_nolock");

        // T2: long idle then 'A'
        do_reset();
        en_state = 4'd5;
        repeat (5000) @(negedge hwclk);
        q.delete();
        q.push_back(8'h41);
        send_stream(q);
        check_frame(8'h41, 8'h01, "T2_A");

        // Holding en_state at 6 after the frame does not repeat it
        en_state = 4'd6;
        repeat (60) @(negedge hwclk);
        chk("hold6_first_bits_done", 32'(mosi), 32'd0);
        begin
            int ones = 0;
            repeat (60) begin
                @(negedge hwclk);
                if (mosi !== 1'b0) ones++;
            end
            chk("hold6_no_repeat", 32'(ones), 32'd0);
        end
        en_state = 4'd0;
        @(negedge hwclk);

        // Table-driven streams
        for (int t = 0; t < 7; t++) begin
            do_reset();
            q.delete();
            for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].b[i]);
            send_stream(q);
            check_frame(tbl[t].exp_char, tbl[t].exp_cnt, tbl[t].name);
        end

        // T4: saturation, followed by a discarded bit7=1 byte
        do_reset();
        q.delete();
        for (int i = 0; i < 300; i++) q.push_back(8'h43);
        q.push_back(8'hC3);
        send_stream(q);
        check_frame(8'h43, 8'hFF, "T4_sat");

        // T5: leave READ mid-byte, then 'B' after re-lock
        do_reset();
        en_state = 4'd5;
        miso = 1'b0;
        repeat (2) @(negedge hwclk);
        miso = 1'b1; repeat (3) @(negedge hwclk);
        miso = 1'b0; repeat (3) @(negedge hwclk);
        miso = 1'b0; repeat (3) @(negedge hwclk);
        en_state = 4'd0;
        repeat (5) @(negedge hwclk);
        q.delete();
        q.push_back(8'h42);
        send_stream(q);
        check_frame(8'h42, 8'h01, "T5_relock");

        // Leaving WRITE mid-frame forces mosi low the next cycle
        en_state = 4'd6;
        repeat (5) @(negedge hwclk);
        chk("abort_pre_bit14", 32'(mosi), 32'd1);
        en_state = 4'd0;
        @(negedge hwclk);
        chk("abort_mosi_low", 32'(mosi), 32'd0);
        @(negedge hwclk);
        check_frame(8'h42, 8'h01, "abort_restart");

        // T6: reset mid-frame
        en_state = 4'd6;
        repeat (5) @(negedge hwclk);
        reset = 1'b1;
        @(negedge hwclk);
        chk("T6_reset_mosi", 32'(mosi), 32'd0);
        reset = 1'b0;
        en_state = 4'd0;
        for (int i = 0; i < 128; i++) mbins[i] = 0;
        @(negedge hwclk);
        check_frame(8'h00, 8'h00, "T6_after_reset");

        // Randomized sessions accumulating into one histogram
        do_reset();
        for (int s = 0; s < 8; s++) begin
            int len;
            q.delete();
            len = $urandom_range(4, 30);
            q.push_back(8'h40 | 8'($urandom_range(0, 63)));
            for (int i = 1; i < len; i++) begin
                if ($urandom_range(0, 7) == 0)
                    q.push_back(8'($urandom));
                else
                    q.push_back({($urandom_range(0, 5) == 0), 7'h40 | 7'($urandom_range(0, 5))});
            end
            send_stream(q);
            en_state = idle_vals[$urandom_range(0, 4)];
            repeat ($urandom_range(1, 6)) @(negedge hwclk);
            model_max(mc, mn);
            check_frame(mc, mn, $sformatf("rand_s%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
